// File: rtl/tof_frame_reader.sv
// ToF ranging-frame reader.
// Once enabled, each rising edge of tof_int starts one burst read of the result frame
// through the shared I2C master handshake. Header and footer bytes are discarded. Payload
// byte pairs are assembled into 16-bit zone distances and streamed with their zone index.
// A frame is aborted on timeout or I2C error. An interrupt edge that arrives while a frame
// is in flight is reported as an overrun and then ignored.
//
// Ports
//   clk, reset     clock, synchronous active-low reset
//   enable         1: arm/acquire, 0: drop to idle (partial frame dropped silently)
//   tof_int        sensor data-ready interrupt (level, already synchronised)
//   i2c_ready      master idle / byte complete; i2c_rdata is valid on its rise
//   i2c_error      master NACK / bus error (level)
//   i2c_rdata      received byte
//   i2c_start      one-cycle burst start request
//   i2c_is_read    read transfer in progress
//   i2c_reg_addr   frame start register address
//   i2c_nb_bytes   bytes remaining after the current one
//   dist_valid     one-cycle strobe qualifying dist_data / zone_index
//   dist_data      zone distance in mm
//   zone_index     zone number 0..ZONES-1
//   frame_done     one-cycle strobe after the last byte of a good frame
//   frame_error    one-cycle strobe on timeout or I2C error abort
//   frame_overrun  one-cycle strobe for an interrupt edge seen while busy
//   frame_count    good frames completed (wrapping)
//   busy           frame in flight
module tof_frame_reader #(
    parameter int unsigned ZONES       = 64,
    parameter int unsigned HDR_BYTES   = 28,
    parameter int unsigned FTR_BYTES   = 24,
    parameter bit          BIG_ENDIAN  = 1'b1,
    parameter logic [15:0] FRAME_ADDR  = 16'h0000,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned ZIDX_W      = $clog2(ZONES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tof_int,
    input  logic              i2c_ready,
    input  logic              i2c_error,
    input  logic [7:0]        i2c_rdata,
    output logic              i2c_start,
    output logic              i2c_is_read,
    output logic [15:0]       i2c_reg_addr,
    output logic [16:0]       i2c_nb_bytes,
    output logic              dist_valid,
    output logic [15:0]       dist_data,
    output logic [ZIDX_W-1:0] zone_index,
    output logic              frame_done,
    output logic              frame_error,
    output logic              frame_overrun,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam int unsigned NBYTES  = HDR_BYTES + 2 * ZONES + FTR_BYTES;
    localparam int unsigned PAY_END = HDR_BYTES + 2 * ZONES;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [16:0]      N_LAST   = 17'(NBYTES - 1);
    localparam logic [16:0]      PAY_LO   = 17'(HDR_BYTES);
    localparam logic [16:0]      PAY_HI   = 17'(PAY_END);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStart,
        StWaitLow,
        StWaitHigh
    } state_e;

    state_e              state_q, state_d;
    logic                tof_q;
    logic [16:0]         byte_cnt_q;
    logic [16:0]         nb_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [7:0]          first_q;
    logic [15:0]         dist_data_q;
    logic [ZIDX_W-1:0]   zone_q;
    logic                dist_valid_q;
    logic                frame_done_q;
    logic                frame_error_q;
    logic                frame_overrun_q;
    logic [15:0]         frame_count_q;

    logic                tof_edge;
    logic                busy_st;
    logic                xfer;
    logic                timeout;
    logic                abort;
    logic                capture;
    logic                last_byte;
    logic                start_go;
    logic                in_payload;
    logic [16:0]         pay_idx;

    always_comb begin
        state_d    = state_q;
        tof_edge   = tof_int & ~tof_q;
        xfer       = (state_q == StWaitLow) || (state_q == StWaitHigh);
        busy_st    = xfer || (state_q == StStart);
        timeout    = xfer && (tmo_cnt_q == TMO_LAST);
        abort      = busy_st && (i2c_error || timeout);
        // Abort and disable both win over a byte arriving in the same cycle.
        capture    = (state_q == StWaitHigh) && i2c_ready && !abort && enable;
        last_byte  = capture && (byte_cnt_q == N_LAST);
        pay_idx    = byte_cnt_q - PAY_LO;
        in_payload = (byte_cnt_q >= PAY_LO) && (byte_cnt_q < PAY_HI);

        case (state_q)
            StIdle:     state_d = StArm;
            StArm:      if (tof_edge) state_d = StStart;
            StStart:    state_d = abort ? StArm : StWaitLow;
            StWaitLow: begin
                if (abort)           state_d = StArm;
                else if (!i2c_ready) state_d = StWaitHigh;
            end
            StWaitHigh: begin
                if (abort)          state_d = StArm;
                else if (last_byte) state_d = StArm;
                else if (capture)   state_d = StWaitLow;
            end
            default:    state_d = StIdle;
        endcase

        if (!enable) state_d = StIdle;
        start_go = (state_q == StArm) && (state_d == StStart);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= StIdle;
            tof_q           <= 1'b0;
            byte_cnt_q      <= '0;
            nb_q            <= '0;
            tmo_cnt_q       <= '0;
            first_q         <= '0;
            dist_data_q     <= '0;
            zone_q          <= '0;
            dist_valid_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
            frame_overrun_q <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            tof_q           <= tof_int;
            dist_valid_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= enable && abort;
            // The edge is consumed here, so it cannot start a frame once busy drops.
            frame_overrun_q <= enable && busy_st && tof_edge;

            if (start_go) begin
                byte_cnt_q <= '0;
                nb_q       <= N_LAST;
                tmo_cnt_q  <= '0;
            end else if (capture) begin
                byte_cnt_q <= byte_cnt_q + 17'd1;
                tmo_cnt_q  <= '0;
                if (nb_q != '0) nb_q <= nb_q - 17'd1;
                if (in_payload) begin
                    if (!pay_idx[0]) begin
                        first_q <= i2c_rdata;
                    end else begin
                        dist_data_q  <= BIG_ENDIAN ? {first_q, i2c_rdata} : {i2c_rdata, first_q};
                        zone_q       <= ZIDX_W'(pay_idx >> 1);
                        dist_valid_q <= 1'b1;
                    end
                end
                if (last_byte) begin
                    frame_done_q  <= 1'b1;
                    frame_count_q <= frame_count_q + 16'd1;
                end
            end else if (xfer) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    assign i2c_start     = (state_q == StStart);
    assign busy          = busy_st;
    assign i2c_is_read   = busy_st;
    assign i2c_reg_addr  = FRAME_ADDR;
    assign i2c_nb_bytes  = nb_q;
    assign dist_valid    = dist_valid_q;
    assign dist_data     = dist_data_q;
    assign zone_index    = zone_q;
    assign frame_done    = frame_done_q;
    assign frame_error   = frame_error_q;
    assign frame_overrun = frame_overrun_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_tof_frame_reader.sv
// Bench for tof_frame_reader: unit 0 is the 8x8 big-endian reader with a short timeout,
// unit 1 the 4x4 little-endian reader. A behavioural I2C master per unit serves bursts and
// pushes expected distances into a per-unit scoreboard queue.
module tb_tof_frame_reader;

    localparam int N0 = 180;
    localparam int N1 = 84;

    logic       clk = 1'b0;
    logic       reset;
    logic       en   [2];
    logic       tof  [2];
    logic       rdy  [2];
    logic       err  [2];
    logic [7:0] rdt  [2];
    logic       kill [2];

    logic        s0, ir0, dv0, fd0, fe0, fo0, bz0;
    logic [15:0] ra0, dd0, fc0;
    logic [16:0] nb0;
    logic [5:0]  zi0;
    logic        s1, ir1, dv1, fd1, fe1, fo1, bz1;
    logic [15:0] ra1, dd1, fc1;
    logic [16:0] nb1;
    logic [3:0]  zi1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_dv [2], n_fd [2], n_fe [2], n_fo [2], n_st [2], n_burst [2];
    int cap_cyc [2], fe_cyc [2], fd_cyc [2];
    int err_at [2], drop_at [2], ovr_at [2], stall_at [2];
    logic [21:0] exp_q0 [$];
    logic [21:0] exp_q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tof_frame_reader #(
        .TIMEOUT_CYC(100)
    ) u_dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .tof_int(tof[0]),
        .i2c_ready(rdy[0]), .i2c_error(err[0]), .i2c_rdata(rdt[0]),
        .i2c_start(s0), .i2c_is_read(ir0), .i2c_reg_addr(ra0), .i2c_nb_bytes(nb0),
        .dist_valid(dv0), .dist_data(dd0), .zone_index(zi0), .frame_done(fd0),
        .frame_error(fe0), .frame_overrun(fo0), .frame_count(fc0), .busy(bz0)
    );

    tof_frame_reader #(
        .ZONES(16),
        .BIG_ENDIAN(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .tof_int(tof[1]),
        .i2c_ready(rdy[1]), .i2c_error(err[1]), .i2c_rdata(rdt[1]),
        .i2c_start(s1), .i2c_is_read(ir1), .i2c_reg_addr(ra1), .i2c_nb_bytes(nb1),
        .dist_valid(dv1), .dist_data(dd1), .zone_index(zi1), .frame_done(fd1),
        .frame_error(fe1), .frame_overrun(fo1), .frame_count(fc1), .busy(bz1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] zval(input int u, input int k);
        if (u == 0) return 16'h0100 + 16'(k);
        return 16'h1234 + 16'(k) * 16'h0111;
    endfunction

    function automatic logic [7:0] bval(input int u, input int b);
        int          zc = (u == 0) ? 64 : 16;
        int          p  = b - 28;
        logic [15:0] v;
        if (b < 28 || b >= 28 + 2 * zc) return 8'(b ^ 32'hA5);
        v = zval(u, p / 2);
        // Unit 0 sends MSB first, unit 1 LSB first.
        if ((p % 2) == 0) return (u == 0) ? v[15:8] : v[7:0];
        return (u == 0) ? v[7:0] : v[15:8];
    endfunction

    task automatic burst(input int u);
        int n  = (u == 0) ? N0 : N1;
        int zc = (u == 0) ? 64 : 16;
        for (int b = 0; b < n; b++) begin
            rdy[u] = 1'b0;
            if (b == err_at[u])  err[u] = 1'b1;
            if (b == drop_at[u]) en[u]  = 1'b0;
            if (b == ovr_at[u])  tof[u] = 1'b1;
            @(posedge clk); #1;
            tof[u] = 1'b0;
            if (kill[u] || b == err_at[u] || b == drop_at[u]) begin
                @(posedge clk); #1;
                err[u] = 1'b0;
                rdy[u] = 1'b1;
                return;
            end
            @(posedge clk); #1;
            if (kill[u]) begin
                rdy[u] = 1'b1;
                return;
            end
            rdt[u] = bval(u, b);
            rdy[u] = 1'b1;
            if (b >= 28 && b < 28 + 2 * zc && ((b - 28) % 2) == 1) begin
                if (u == 0) exp_q0.push_back({6'((b - 28) / 2), zval(0, (b - 28) / 2)});
                else        exp_q1.push_back({6'((b - 28) / 2), zval(1, (b - 28) / 2)});
            end
            @(posedge clk); #1;
            cap_cyc[u] = cyc;
            if (b == stall_at[u]) begin
                rdy[u] = 1'b0;
                return;
            end
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (s0 === 1'b1 && !kill[0]) begin
            burst(0);
            n_burst[0]++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (s1 === 1'b1 && !kill[1]) begin
            burst(1);
            n_burst[1]++;
        end
    end

    task automatic mon(input int u, input logic st, input logic [16:0] nb, input logic rd,
                       input logic bz, input logic dv, input logic [15:0] dd,
                       input logic [5:0] zi, input logic fd, input logic fe, input logic fo);
        logic [21:0] e;
        if (st === 1'b1) begin
            n_st[u]++;
            check_eq("start_nb_bytes", 32'(nb), (u == 0) ? 32'(N0 - 1) : 32'(N1 - 1));
            check_eq("start_is_read", 32'(rd), 32'd1);
            check_eq("start_busy", 32'(bz), 32'd1);
        end
        if (dv === 1'b1) begin
            n_dv[u]++;
            if (u == 0 && exp_q0.size() == 0 || u == 1 && exp_q1.size() == 0) begin
                check_eq("dist_unexpected", 32'(dv), 32'd0);
            end else begin
                e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check_eq((u == 0) ? "dist_u0" : "dist_u1", 32'({zi, dd}), 32'(e));
            end
        end
        if (fd === 1'b1) begin
            n_fd[u]++;
            fd_cyc[u] = cyc;
        end
        if (fe === 1'b1) begin
            n_fe[u]++;
            fe_cyc[u] = cyc;
        end
        if (fo === 1'b1) n_fo[u]++;
    endtask

    always @(negedge clk) begin
        mon(0, s0, nb0, ir0, bz0, dv0, dd0, zi0, fd0, fe0, fo0);
        mon(1, s1, nb1, ir1, bz1, dv1, dd1, {2'b00, zi1}, fd1, fe1, fo1);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic kick(input int u);
        tof[u] = 1'b1;
        cycles(1);
        tof[u] = 1'b0;
    endtask

    // Fire one interrupt and wait for the master model to finish serving the burst.
    task automatic frame(input int u, input string tag);
        int b0 = n_burst[u];
        kick(u);
        for (int i = 0; i < 2000 && n_burst[u] == b0; i++) cycles(1);
        if (n_burst[u] == b0) check_eq({tag, "_burst_end"}, 32'(n_burst[u] - b0), 32'd1);
        cycles(3);
    endtask

    int d_dv, d_fd, d_fe, d_fo;

    task automatic snap(input int u);
        d_dv = n_dv[u];
        d_fd = n_fd[u];
        d_fe = n_fe[u];
        d_fo = n_fo[u];
    endtask

    initial begin
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            en[u] = 1'b0; tof[u] = 1'b0; rdy[u] = 1'b1; err[u] = 1'b0; rdt[u] = '0;
            kill[u] = 1'b0; err_at[u] = -1; drop_at[u] = -1; ovr_at[u] = -1; stall_at[u] = -1;
            n_dv[u] = 0; n_fd[u] = 0; n_fe[u] = 0; n_fo[u] = 0; n_st[u] = 0; n_burst[u] = 0;
            cap_cyc[u] = 0; fe_cyc[u] = 0; fd_cyc[u] = 0;
        end
        cycles(3);
        check_eq("rst_busy", 32'(bz0), 32'd0);
        check_eq("rst_start", 32'(s0), 32'd0);
        check_eq("rst_is_read", 32'(ir0), 32'd0);
        check_eq("rst_nb_bytes", 32'(nb0), 32'd0);
        check_eq("rst_frame_count", 32'(fc0), 32'd0);
        check_eq("rst_reg_addr", 32'(ra0), 32'h0000);
        reset = 1'b1;

        // Interrupt already high when arming must not start a frame.
        tof[0] = 1'b1;
        cycles(2);
        en[0] = 1'b1;
        en[1] = 1'b1;
        cycles(10);
        check_eq("level_no_start", 32'(n_st[0]), 32'd0);
        tof[0] = 1'b0;
        cycles(3);

        // 1: full 8x8 big-endian frame.
        snap(0);
        frame(0, "t1");
        check_eq("t1_dist_count", 32'(n_dv[0] - d_dv), 32'd64);
        check_eq("t1_done", 32'(n_fd[0] - d_fd), 32'd1);
        check_eq("t1_error", 32'(n_fe[0] - d_fe), 32'd0);
        check_eq("t1_frame_count", 32'(fc0), 32'd1);
        check_eq("t1_busy_after", 32'(bz0), 32'd0);

        // 2: 4x4 little-endian frame, done strobe right after byte 83.
        snap(1);
        frame(1, "t2");
        check_eq("t2_dist_count", 32'(n_dv[1] - d_dv), 32'd16);
        check_eq("t2_done", 32'(n_fd[1] - d_fd), 32'd1);
        check_eq("t2_done_timing", 32'(fd_cyc[1] - cap_cyc[1]), 32'd0);
        check_eq("t2_frame_count", 32'(fc1), 32'd1);

        // 3: master stalls after byte 50, abort exactly TIMEOUT_CYC later.
        snap(0);
        stall_at[0] = 50;
        frame(0, "t3");
        for (int i = 0; i < 300 && n_fe[0] == d_fe; i++) cycles(1);
        check_eq("t3_error", 32'(n_fe[0] - d_fe), 32'd1);
        check_eq("t3_timeout_cycles", 32'(fe_cyc[0] - cap_cyc[0]), 32'd100);
        check_eq("t3_no_done", 32'(n_fd[0] - d_fd), 32'd0);
        check_eq("t3_dist_count", 32'(n_dv[0] - d_dv), 32'd11);
        check_eq("t3_frame_count", 32'(fc0), 32'd1);
        stall_at[0] = -1;
        rdy[0] = 1'b1;
        cycles(3);
        snap(0);
        frame(0, "t3b");
        check_eq("t3b_done", 32'(n_fd[0] - d_fd), 32'd1);
        check_eq("t3b_frame_count", 32'(fc0), 32'd2);

        // 4: bus error during byte 30, then overrun edge during byte 100.
        snap(0);
        err_at[0] = 30;
        frame(0, "t4");
        check_eq("t4_error", 32'(n_fe[0] - d_fe), 32'd1);
        check_eq("t4_dist_count", 32'(n_dv[0] - d_dv), 32'd1);
        check_eq("t4_frame_count", 32'(fc0), 32'd2);
        check_eq("t4_busy_after", 32'(bz0), 32'd0);
        err_at[0] = -1;
        snap(0);
        ovr_at[0] = 100;
        frame(0, "t4b");
        check_eq("t4b_overrun", 32'(n_fo[0] - d_fo), 32'd1);
        check_eq("t4b_done", 32'(n_fd[0] - d_fd), 32'd1);
        check_eq("t4b_dist_count", 32'(n_dv[0] - d_dv), 32'd64);
        check_eq("t4b_frame_count", 32'(fc0), 32'd3);
        ovr_at[0] = -1;

        // 5: disable at byte 90 drops the frame silently, a fresh frame follows.
        snap(0);
        drop_at[0] = 90;
        frame(0, "t5");
        cycles(5);
        check_eq("t5_no_done", 32'(n_fd[0] - d_fd), 32'd0);
        check_eq("t5_no_error", 32'(n_fe[0] - d_fe), 32'd0);
        check_eq("t5_no_overrun", 32'(n_fo[0] - d_fo), 32'd0);
        check_eq("t5_dist_count", 32'(n_dv[0] - d_dv), 32'd31);
        check_eq("t5_busy", 32'(bz0), 32'd0);
        check_eq("t5_frame_count", 32'(fc0), 32'd3);
        drop_at[0] = -1;
        en[0] = 1'b1;
        cycles(3);
        snap(0);
        frame(0, "t5b");
        check_eq("t5b_done", 32'(n_fd[0] - d_fd), 32'd1);
        check_eq("t5b_dist_count", 32'(n_dv[0] - d_dv), 32'd64);
        check_eq("t5b_frame_count", 32'(fc0), 32'd4);

        // Reset in the middle of a frame clears every output on the next edge.
        kick(0);
        cycles(150);
        @(negedge clk);
        reset   = 1'b0;
        kill[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_busy", 32'(bz0), 32'd0);
        check_eq("mid_rst_is_read", 32'(ir0), 32'd0);
        check_eq("mid_rst_nb_bytes", 32'(nb0), 32'd0);
        check_eq("mid_rst_dist", 32'({dv0, zi0, dd0}), 32'd0);
        check_eq("mid_rst_strobes", 32'({s0, fd0, fe0, fo0}), 32'd0);
        check_eq("mid_rst_frame_count", 32'(fc0), 32'd0);
        check_eq("mid_rst_reg_addr", 32'(ra0), 32'h0000);
        cycles(5);
        exp_q0.delete();
        kill[0] = 1'b0;
        rdy[0]  = 1'b1;
        reset   = 1'b1;
        cycles(5);
        snap(0);
        frame(0, "post_rst");
        check_eq("post_rst_done", 32'(n_fd[0] - d_fd), 32'd1);
        check_eq("post_rst_frame_count", 32'(fc0), 32'd1);

        check_eq("scoreboard_u0_empty", 32'(exp_q0.size()), 32'd0);
        check_eq("scoreboard_u1_empty", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
